lms_stimulus_gen: RTL and testbench

LMS_STIMULUS_GEN -- requirements
Module: lms_stimulus_gen

---
 rtl/lms_stimulus_gen.sv | 170 +++++++++++++++++
 tb/tb_lms_stimulus_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lms_stimulus_gen.sv
// lms_stimulus_gen
// Burst stimulus source for an LMS adaptive filter. Each sample pair is
// x[n] = low DATA_WIDTH bits of a 16-bit Fibonacci LFSR and
// d[n] = (x>>>1) + (x1>>>2) + (x2>>>3), where x1/x2 are the previous two
// accepted x samples of the current burst. Samples are handed over with a
// valid/ready handshake; the LFSR only moves on accepted transfers and keeps
// running across bursts.
//
// Optional feature: define LMS_STIM_NOISE_EN to add a small pseudo-random
// offset (sign-extended LFSR[15:13], -4..+3) to ref_out, wrapping.
module lms_stimulus_gen #(
  parameter int          DATA_WIDTH = 12,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                  clk_in,
  input  logic                  resetn_in,
  input  logic                  start_in,
  input  logic [15:0]           burst_len_in,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] x_out,
  output logic [DATA_WIDTH-1:0] ref_out,
  output logic                  valid_out,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // One LFSR advance: shift left, feedback taps 15/13/12/10 enter at bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference sample from current and two past x values; wraps, no saturation.
  function automatic logic [DATA_WIDTH-1:0] ref_calc(
    input logic [DATA_WIDTH-1:0] x,
    input logic [DATA_WIDTH-1:0] x1,
    input logic [DATA_WIDTH-1:0] x2
  );
    logic signed [DATA_WIDTH-1:0] sum;
    sum = ($signed(x) >>> 3'd1) + ($signed(x1) >>> 3'd2) + ($signed(x2) >>> 3'd3);
    return sum;
  endfunction

`ifdef LMS_STIM_NOISE_EN
  // Small signed offset taken from the LFSR top bits.
  function automatic logic [DATA_WIDTH-1:0] noise_of(input logic [15:0] v);
    return {{(DATA_WIDTH-3){v[15]}}, v[15:13]};
  endfunction
`endif

  logic [1:0]            state_r;
  logic [15:0]           lfsr_r;
  logic [DATA_WIDTH-1:0] x1_r;
  logic [DATA_WIDTH-1:0] x2_r;
  logic [15:0]           cnt_r;
  logic                  valid_r;
  logic                  busy_r;
  logic                  done_r;
  logic [DATA_WIDTH-1:0] ref_r;

  logic [1:0]            state_nxt_s;
  logic [15:0]           lfsr_nxt_s;
  logic [DATA_WIDTH-1:0] x1_nxt_s;
  logic [DATA_WIDTH-1:0] x2_nxt_s;
  logic [15:0]           cnt_nxt_s;
  logic                  valid_nxt_s;
  logic                  xfer_s;
  logic [DATA_WIDTH-1:0] ref_nxt_s;
  logic [DATA_WIDTH-1:0] ref_seed_s;

  assign xfer_s    = valid_r & ready_in;
  assign x_out     = lfsr_r[DATA_WIDTH-1:0];
  assign ref_out   = ref_r;
  assign valid_out = valid_r;
  assign busy_out  = busy_r;
  assign done_out  = done_r;

  // Next-state logic: FSM, handshake, LFSR advance and delay-line shift.
  always_comb begin
    state_nxt_s = state_r;
    lfsr_nxt_s  = lfsr_r;
    x1_nxt_s    = x1_r;
    x2_nxt_s    = x2_r;
    cnt_nxt_s   = cnt_r;
    valid_nxt_s = valid_r;
    case (state_r)
      ST_IDLE: begin
        if (start_in) begin
          // History is cleared on every accepted start, empty bursts included.
          x1_nxt_s = {DATA_WIDTH{1'b0}};
          x2_nxt_s = {DATA_WIDTH{1'b0}};
          if (burst_len_in != 16'd0) begin
            state_nxt_s = ST_RUN;
            cnt_nxt_s   = burst_len_in;
            valid_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_DONE;
            valid_nxt_s = 1'b0;
          end
        end else begin
          valid_nxt_s = 1'b0;
        end
      end
      ST_RUN: begin
        if (xfer_s) begin
          lfsr_nxt_s = lfsr_step(lfsr_r);
          x1_nxt_s   = lfsr_r[DATA_WIDTH-1:0];
          x2_nxt_s   = x1_r;
          cnt_nxt_s  = cnt_r - 16'd1;
          if (cnt_r == 16'd1) begin
            state_nxt_s = ST_DONE;
            valid_nxt_s = 1'b0;
          end else begin
            valid_nxt_s = 1'b1;
          end
        end else begin
          valid_nxt_s = valid_r;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        valid_nxt_s = 1'b0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Reference value for the next register contents and for the reset image.
  always_comb begin
`ifdef LMS_STIM_NOISE_EN
    ref_nxt_s  = ref_calc(lfsr_nxt_s[DATA_WIDTH-1:0], x1_nxt_s, x2_nxt_s) + noise_of(lfsr_nxt_s);
    ref_seed_s = ref_calc(SEED[DATA_WIDTH-1:0], {DATA_WIDTH{1'b0}}, {DATA_WIDTH{1'b0}}) + noise_of(SEED);
`else
    ref_nxt_s  = ref_calc(lfsr_nxt_s[DATA_WIDTH-1:0], x1_nxt_s, x2_nxt_s);
    ref_seed_s = ref_calc(SEED[DATA_WIDTH-1:0], {DATA_WIDTH{1'b0}}, {DATA_WIDTH{1'b0}});
`endif
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!resetn_in) begin
      state_r <= ST_IDLE;
      lfsr_r  <= SEED;
      x1_r    <= {DATA_WIDTH{1'b0}};
      x2_r    <= {DATA_WIDTH{1'b0}};
      cnt_r   <= 16'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ref_r   <= ref_seed_s;
    end else begin
      state_r <= state_nxt_s;
      lfsr_r  <= lfsr_nxt_s;
      x1_r    <= x1_nxt_s;
      x2_r    <= x2_nxt_s;
      cnt_r   <= cnt_nxt_s;
      valid_r <= valid_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= (state_nxt_s == ST_DONE);
      ref_r   <= ref_nxt_s;
    end
  end

endmodule

// File: tb/tb_lms_stimulus_gen.sv
// Testbench for lms_stimulus_gen (default parameters, noise feature off).
// Stimulus pushes expected {x, ref} pairs into a queue; a monitor pops and
// compares on every accepted transfer. Directed checks cover reset image,
// backpressure, burst length, empty bursts, reset abort and start-in-RUN.
module tb_lms_stimulus_gen;

  logic        clk_in = 1'b0;
  logic        resetn_in;
  logic        start_in;
  logic [15:0] burst_len_in;
  logic        ready_in;
  logic [11:0] x_out;
  logic [11:0] ref_out;
  logic        valid_out;
  logic        busy_out;
  logic        done_out;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;

  logic [23:0] exp_q[$];
  logic [15:0] m_lfsr;
  int          m_x1;
  int          m_x2;

  always #5 clk_in = ~clk_in;

  lms_stimulus_gen #(.DATA_WIDTH(12), .SEED(16'hACE1)) dut (
    .clk_in       (clk_in),
    .resetn_in    (resetn_in),
    .start_in     (start_in),
    .burst_len_in (burst_len_in),
    .ready_in     (ready_in),
    .x_out        (x_out),
    .ref_out      (ref_out),
    .valid_out    (valid_out),
    .busy_out     (busy_out),
    .done_out     (done_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Reference model: produce n expected samples and advance the model LFSR.
  task automatic push_model(input int n);
    logic [11:0] xv;
    int xs;
    int r;
    for (int i = 0; i < n; i++) begin
      xv = m_lfsr[11:0];
      xs = xv[11] ? int'(xv) - 4096 : int'(xv);
      r  = (xs >>> 1) + (m_x1 >>> 2) + (m_x2 >>> 3);
      exp_q.push_back({xv, r[11:0]});
      m_x2   = m_x1;
      m_x1   = xs;
      m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    end
  endtask

  task automatic start_burst(input logic [15:0] len, input int n, input logic rdy, input bit hold);
    burst_len_in = len;
    ready_in     = rdy;
    start_in     = 1'b1;
    m_x1 = 0;
    m_x2 = 0;
    push_model(n);
    tick();
    if (!hold) start_in = 1'b0;
  endtask

  task automatic do_reset();
    resetn_in = 1'b0;
    tick();
    resetn_in = 1'b1;
    m_lfsr = 16'hACE1;
    m_x1 = 0;
    m_x2 = 0;
  endtask

  // Wait (bounded) for done, then check the pulse shape and busy release.
  task automatic wait_done(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in);
      if (done_out === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      start_in = 1'b0;
      check({name, "_valid_in_done"}, 32'(valid_out), 32'd0);
      check({name, "_busy_in_done"}, 32'(busy_out), 32'd1);
      tick();
      @(negedge clk_in);
      check({name, "_done_1cyc"}, 32'(done_out), 32'd0);
      check({name, "_busy_after"}, 32'(busy_out), 32'd0);
    end
  endtask

  // Scoreboard monitor: compare every accepted transfer against the queue.
  always @(negedge clk_in) begin : monitor
    logic [23:0] e;
    if (resetn_in === 1'b1 && done_out === 1'b1) done_cnt++;
    if (resetn_in === 1'b1 && valid_out === 1'b1 && ready_in === 1'b1) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got x=0x%0h ref=0x%0h expected no transfer", x_out, ref_out);
      end else begin
        e = exp_q.pop_front();
        check("sb_x", 32'(x_out), 32'(e[23:12]));
        check("sb_ref", 32'(ref_out), 32'(e[11:0]));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base_x;
    int base_d;
    logic [23:0] hold_e;
    resetn_in    = 1'b0;
    start_in     = 1'b0;
    burst_len_in = 16'd0;
    ready_in     = 1'b0;
    m_lfsr = 16'hACE1;
    m_x1 = 0;
    m_x2 = 0;
    tick();
    tick();
    resetn_in = 1'b1;

    // Reset image: seed sample with zero history, all flags low.
    @(negedge clk_in);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_done", 32'(done_out), 32'd0);
    check("rst_x", 32'(x_out), 32'h0CE1);
    check("rst_ref", 32'(ref_out), 32'h0E70);
    tick();

    // Burst of 3 with hand-computed samples.
    start_burst(16'd3, 3, 1'b1, 1'b0);
    @(negedge clk_in);
    check("b3_valid", 32'(valid_out), 32'd1);
    check("b3_busy", 32'(busy_out), 32'd1);
    check("b3_x0", 32'(x_out), 32'h0CE1);
    check("b3_ref0", 32'(ref_out), 32'h0E70);
    tick();
    @(negedge clk_in);
    check("b3_x1", 32'(x_out), 32'h09C3);
    check("b3_ref1", 32'(ref_out), 32'h0C19);
    tick();
    @(negedge clk_in);
    check("b3_x2", 32'(x_out), 32'h0387);
    check("b3_ref2", 32'(ref_out), 32'h0FCF);
    wait_done(10, "b3");
    tick();

    // Backpressure: ready low for 5 cycles, sample must hold.
    start_burst(16'd2, 2, 1'b0, 1'b0);
    hold_e = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      check("bp_valid", 32'(valid_out), 32'd1);
      check("bp_x", 32'(x_out), 32'(hold_e[23:12]));
      check("bp_ref", 32'(ref_out), 32'(hold_e[11:0]));
      tick();
    end
    ready_in = 1'b1;
    wait_done(10, "bp");
    tick();

    // Burst of 4: exactly four transfers.
    base_x = xfer_cnt;
    start_burst(16'd4, 4, 1'b1, 1'b0);
    wait_done(20, "b4");
    tick();
    check("b4_xfers", 32'(xfer_cnt - base_x), 32'd4);

    // Zero-length burst: done one cycle after start, never valid.
    base_x = xfer_cnt;
    start_burst(16'd0, 0, 1'b1, 1'b0);
    @(negedge clk_in);
    check("b0_done", 32'(done_out), 32'd1);
    check("b0_valid", 32'(valid_out), 32'd0);
    check("b0_busy", 32'(busy_out), 32'd1);
    tick();
    @(negedge clk_in);
    check("b0_done_off", 32'(done_out), 32'd0);
    check("b0_busy_off", 32'(busy_out), 32'd0);
    tick();
    check("b0_xfers", 32'(xfer_cnt - base_x), 32'd0);

    // Length 0xFFFF: still running after 20 transfers, then abort by reset.
    base_x = xfer_cnt;
    base_d = done_cnt;
    start_burst(16'hFFFF, 20, 1'b1, 1'b0);
    repeat (20) tick();
    ready_in = 1'b0;
    tick();
    check("ff_xfers", 32'(xfer_cnt - base_x), 32'd20);
    @(negedge clk_in);
    check("ff_busy", 32'(busy_out), 32'd1);
    check("ff_valid", 32'(valid_out), 32'd1);
    tick();
    do_reset();
    @(negedge clk_in);
    check("ff_rst_busy", 32'(busy_out), 32'd0);
    tick();
    check("ff_no_done", 32'(done_cnt - base_d), 32'd0);

    // Reset after 2 of 10 samples, then restart from the seed.
    base_d = done_cnt;
    start_burst(16'd10, 2, 1'b1, 1'b0);
    tick();
    tick();
    ready_in = 1'b0;
    do_reset();
    @(negedge clk_in);
    check("ra_valid", 32'(valid_out), 32'd0);
    check("ra_busy", 32'(busy_out), 32'd0);
    check("ra_x", 32'(x_out), 32'h0CE1);
    check("ra_ref", 32'(ref_out), 32'h0E70);
    tick();
    tick();
    check("ra_no_done", 32'(done_cnt - base_d), 32'd0);
    start_burst(16'd1, 1, 1'b1, 1'b0);
    @(negedge clk_in);
    check("ra_restart_x", 32'(x_out), 32'h0CE1);
    wait_done(10, "ra");
    tick();

    // start_in held high during RUN with a changed length: ignored.
    base_x = xfer_cnt;
    base_d = done_cnt;
    start_burst(16'd3, 3, 1'b1, 1'b1);
    burst_len_in = 16'd7;
    wait_done(20, "sh");
    repeat (4) tick();
    @(negedge clk_in);
    check("sh_valid", 32'(valid_out), 32'd0);
    check("sh_busy", 32'(busy_out), 32'd0);
    tick();
    check("sh_xfers", 32'(xfer_cnt - base_x), 32'd3);
    check("sh_dones", 32'(done_cnt - base_d), 32'd1);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
